lsu_align_stage: RTL
====================

Name: lsu_align_stage

Overview:
- Sits between the EXU and the LSU.
- Accepts RISC-V load/store requests with a byte address and funct3. Converts them into word-aligned LSU requests: word address, shifted write data, 4-bit byte strobe.
- On loads, extracts and sign/zero-extends the addressed byte, half or word from the returned word.
- Holds one request at a time. All LSU-side outputs are registered, so the LSU always sees stable mem_* signals.

Parameters:
- ADDR_W, 32, width of req_addr/mem_addr.
- ZERO_LOW_BITS, 1, when 1 mem_addr[1:0] is forced to 2'b00; when 0 the request address passes through unmodified.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset; state cleared on the rising clock edge while reset==0.
- req_valid  in  1  EXU request valid.
- req_ready  out  1  stage can accept a request.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_wen  in  1  1=store, 0=load.
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- resp_valid  out  1  response valid to EXU.
- resp_ready  in  1  EXU accepts response.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_err  out  1  request rejected (illegal funct3 / misaligned).
- mem_valid  out  1  request to LSU.
- mem_addr  out  ADDR_W  word address to LSU.
- mem_wdata  out  32  lane-shifted store data.
- mem_wmask  out  4  byte strobe.
- mem_wen  out  1  store enable.
- mem_ready  in  1  LSU completion pulse, one cycle.
- mem_rdata  in  32  LSU read word; valid only while mem_ready=1.

Behaviour:
- Reset values (reset==0): state=IDLE; req_ready=0 during reset; resp_valid, resp_err, mem_valid, mem_wen=0; resp_rdata, mem_addr, mem_wdata=0; mem_wmask=4'b0000.
- After reset release, req_ready=1 in IDLE.
- FSM states IDLE, ISSUE, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch the request. Then:
  - funct3 illegal (011, 110, 111; for stores also 100, 101) -> RESP with resp_err=1.
  - Otherwise -> ISSUE. mem_valid=1 and mem_* are driven from the latched request starting the next cycle.
- ISSUE: req_ready=0. mem_valid and all mem_* are held constant until the mem_ready cycle.
  - On mem_ready=1: capture the load result from mem_rdata that cycle, clear mem_valid at the same edge, go to RESP. mem_valid is therefore never high in the cycle after mem_ready.
  - mem_ready while not in ISSUE is ignored.
- RESP: resp_valid=1; resp_rdata and resp_err held stable.
  - resp_valid&&resp_ready -> IDLE.
  - A new request is not accepted in the same cycle; minimum 1 idle cycle between back-to-back requests.
- Latency: request accepted at edge T; mem_valid high in cycle T+1; resp_valid in the cycle after mem_ready. Error path: resp_valid in cycle T+1.
- Store lane rules, with o=addr[1:0]:
  - mem_wmask = base << o, where base is B 0001, H 0011, W 1111.
  - mem_wdata = req_wdata << (8*o).
- Load extract: sh = mem_rdata >> (8*o).
  - B/H: sign-extend from bit 7/15.
  - BU/HU: zero-extend.
  - W: sh unchanged.
- Loads drive mem_wen=0 and mem_wmask=0000.
- Stores drive resp_rdata=0.
- mem_addr = req_addr with bits [1:0] zeroed when ZERO_LOW_BITS=1.
- Reset mid-operation returns to IDLE and drops mem_valid immediately. The LSU must be reset in the same cycle; a late mem_ready after reset is ignored.

Optional Feature:
- Macro: LSU_ALIGN_MISALIGN_CHECK_EN.
- Defined: H/HU with addr[0]=1, or W with addr[1:0]!=00, takes the error path. Nothing is issued to the LSU; resp_err=1 and resp_rdata=0.
- Undefined: no check. Halfword at o=3 sets mem_wmask=1000 and mem_wdata=req_wdata<<24 (upper byte dropped); a load at o=3 extracts from mem_rdata>>24. Words use o as given.

Test Plan:
- SB addr=0x80000003, wdata=0x000000AB -> mem_addr=0x80000000, mem_wmask=1000, mem_wdata=0xAB000000, mem_wen=1. After a mem_ready pulse: resp_valid=1, resp_rdata=0, resp_err=0.
- LB addr=0x80000001, mem_rdata=0x0000F000 -> resp_rdata=0xFFFFFFF0. The same with LBU -> 0x000000F0.
- LH addr=0x80000002, mem_rdata=0x8001FFFF -> resp_rdata=0xFFFF8001. LHU -> 0x00008001.
- funct3=011 -> mem_valid stays 0, resp_valid in cycle T+1 with resp_err=1. With LSU_ALIGN_MISALIGN_CHECK_EN, LW addr=0x80000002 gives the same response.
- Hold resp_ready=0 for 5 cycles -> resp_valid/resp_rdata stable and req_ready=0. On release, IDLE follows.
- Assert reset=0 during ISSUE -> next cycle mem_valid=0, resp_valid=0. A mem_ready pulse after reset release produces no response.

Source files
------------

// File: rtl/lsu_align_stage.sv
// Converts byte-addressed RISC-V load/store requests into word-aligned LSU requests and extends load data.
// Optional misalignment rejection is enabled by defining LSU_ALIGN_MISALIGN_CHECK_EN.
module lsu_align_stage #(
  parameter int ADDR_W        = 32,
  parameter bit ZERO_LOW_BITS = 1'b1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic              req_wen_i,
  input  logic [2:0]        req_funct3_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_err_o,
  output logic              mem_valid_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_wmask_o,
  output logic              mem_wen_o,
  input  logic              mem_ready_i,
  input  logic [31:0]       mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state_q, state_d;
  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wmask_q, mem_wmask_d;
  logic              mem_wen_q, mem_wen_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        f3_q, f3_d;
  logic              wen_q, wen_d;

  logic [1:0]  off;
  logic        f3_ok, misalign;
  logic [3:0]  base_mask;
  logic [31:0] sh, ext;

  assign off = req_addr_i[1:0];

  always_comb begin
    f3_ok = 1'b0;
    case (req_funct3_i)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = ~req_wen_i;
      default:                f3_ok = 1'b0;
    endcase
`ifdef LSU_ALIGN_MISALIGN_CHECK_EN
    misalign = ((req_funct3_i[1:0] == 2'b01) && off[0]) ||
               ((req_funct3_i[1:0] == 2'b10) && (off != 2'b00));
`else
    misalign = 1'b0;
`endif
    case (req_funct3_i[1:0])
      2'b00:   base_mask = 4'b0001;
      2'b01:   base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
  end

  // Load extraction works off the offset/size latched at accept time.
  always_comb begin
    sh = mem_rdata_i >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ext = {{24{sh[7]}}, sh[7:0]};
      3'b001:  ext = {{16{sh[15]}}, sh[15:0]};
      3'b100:  ext = {24'h0, sh[7:0]};
      3'b101:  ext = {16'h0, sh[15:0]};
      default: ext = sh;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wmask_d  = mem_wmask_q;
    mem_wen_d    = mem_wen_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    off_d        = off_q;
    f3_d         = f3_q;
    wen_d        = wen_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          off_d        = off;
          f3_d         = req_funct3_i;
          wen_d        = req_wen_i;
          resp_rdata_d = 32'h0;
          if (!f3_ok || misalign) begin
            resp_err_d = 1'b1;
            state_d    = RESP;
          end else begin
            resp_err_d  = 1'b0;
            state_d     = ISSUE;
            mem_valid_d = 1'b1;
            mem_addr_d  = ZERO_LOW_BITS ? {req_addr_i[ADDR_W-1:2], 2'b00} : req_addr_i;
            mem_wen_d   = req_wen_i;
            mem_wmask_d = req_wen_i ? (base_mask << off) : 4'b0000;
            mem_wdata_d = req_wen_i ? (req_wdata_i << {off, 3'b000}) : 32'h0;
          end
        end
      end
      ISSUE: begin
        if (mem_ready_i) begin
          mem_valid_d  = 1'b0;
          resp_rdata_d = wen_q ? 32'h0 : ext;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q      <= IDLE;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
      mem_wmask_q  <= 4'b0000;
      mem_wen_q    <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      off_q        <= 2'b00;
      f3_q         <= 3'b000;
      wen_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wmask_q  <= mem_wmask_d;
      mem_wen_q    <= mem_wen_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      off_q        <= off_d;
      f3_q         <= f3_d;
      wen_q        <= wen_d;
    end
  end

  assign req_ready_o  = reset_i && (state_q == IDLE);
  assign resp_valid_o = (state_q == RESP);
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
  assign mem_valid_o  = mem_valid_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign mem_wmask_o  = mem_wmask_q;
  assign mem_wen_o    = mem_wen_q;

endmodule
